lif_timestep_scheduler: RTL



---
 rtl/lif_timestep_scheduler_if.sv | 25 ++
 rtl/lif_timestep_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lif_timestep_scheduler_if.sv
// rtl/lif_timestep_scheduler_if.sv - control/monitor bundle for the LIF timestep scheduler
interface lif_timestep_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  logic                 ena;
  logic                 tick;
  logic [WIDTH-1:0]     ext_in;
  logic [2:0]           mon_sel;
  logic [N_NEURONS-1:0] spikes;
  logic                 done;
  logic                 busy;
  logic                 overrun;
  logic [WIDTH-1:0]     mon_v;

  modport master (
    output ena, tick, ext_in, mon_sel,
    input  spikes, done, busy, overrun, mon_v
  );

  modport slave (
    input  ena, tick, ext_in, mon_sel,
    output spikes, done, busy, overrun, mon_v
  );
endinterface

// File: rtl/lif_timestep_scheduler.sv
// rtl/lif_timestep_scheduler.sv - one shared LIF datapath sequenced across a feed-forward neuron chain
module lif_timestep_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int WIDTH        = 8,
  parameter int THRESHOLD    = 200,
  parameter int LEAK_SHIFT   = 1,
  parameter int WEIGHT       = 120,
  parameter int REFRAC_STEPS = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  lif_timestep_scheduler_if.slave   bus
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC_STEPS < 2) ? 1 : $clog2(REFRAC_STEPS + 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [WIDTH-1:0]     cur0_q;
  logic [WIDTH-1:0]     v_q [N_NEURONS];
  logic [RW-1:0]        refrac_q [N_NEURONS];
  logic [N_NEURONS-1:0] work_q;
  logic [N_NEURONS-1:0] work_nxt;
  logic [N_NEURONS-1:0] spikes_q;
  logic                 done_q;
  logic                 overrun_q;

  logic                 accept;
  logic                 step;
  logic                 last;
  logic [WIDTH-1:0]     v_cur;
  logic [RW-1:0]        r_cur;
  logic                 prev_spk;
  logic [WIDTH-1:0]     i_cur;
  logic [WIDTH:0]       vn_wide;
  logic [WIDTH-1:0]     vn_sat;
  logic                 fire;
  logic [WIDTH-1:0]     mon_v_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept a tick in IDLE, walk the neurons in UPDATE until the last one
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tick && bus.ena) begin
          accept  = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        step = 1'b1;
        if (idx_q == IW'(N_NEURONS - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared LIF datapath for the neuron currently addressed by idx
  always_comb begin
    v_cur    = '0;
    r_cur    = '0;
    prev_spk = 1'b0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (idx_q == IW'(i)) begin
        v_cur = v_q[i];
        r_cur = refrac_q[i];
      end
    end
    for (int i = 1; i < N_NEURONS; i++) begin
      if (idx_q == IW'(i)) prev_spk = work_q[i-1];
    end
    i_cur   = (idx_q == '0) ? cur0_q : (prev_spk ? WIDTH'(WEIGHT) : '0);
    // v - (v >> k) can never go negative, so only the top end needs saturation
    vn_wide = {1'b0, v_cur} - {1'b0, (v_cur >> LEAK_SHIFT)} + {1'b0, i_cur};
    vn_sat  = vn_wide[WIDTH] ? '1 : vn_wide[WIDTH-1:0];
    fire    = (r_cur == '0) && (vn_sat >= WIDTH'(THRESHOLD));
    work_nxt = work_q;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (idx_q == IW'(i)) work_nxt[i] = fire;
    end
  end

  // Sequencing index, captured stimulus, working/published spike vectors and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cur0_q    <= '0;
      work_q    <= '0;
      spikes_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= last;
      if (state_q == UPDATE && bus.tick && bus.ena) overrun_q <= 1'b1;
      if (accept) begin
        idx_q  <= '0;
        cur0_q <= bus.ext_in;
        work_q <= '0;
      end else if (step) begin
        idx_q  <= last ? '0 : idx_q + IW'(1);
        work_q <= work_nxt;
      end
      // Last neuron's spike is folded in on the same edge it is computed
      if (last) spikes_q <= work_nxt;
    end
  end

  // Membrane and refractory state written back for the addressed neuron only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (idx_q == IW'(i)) begin
          if (r_cur != '0) begin
            v_q[i]      <= '0;
            refrac_q[i] <= r_cur - RW'(1);
          end else if (fire) begin
            v_q[i]      <= '0;
            refrac_q[i] <= RW'(REFRAC_STEPS);
          end else begin
            v_q[i]      <= vn_sat;
          end
        end
      end
    end
  end

  // Membrane monitor; out-of-range selects read as zero
  always_comb begin
    mon_v_c = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (bus.mon_sel == 3'(i)) mon_v_c = v_q[i];
    end
  end

  assign bus.spikes  = spikes_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == UPDATE);
  assign bus.overrun = overrun_q;
  assign bus.mon_v   = mon_v_c;

endmodule
